uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- UART 8N1 transmitter directly downstream of the GPIO button/switch block.
- Consumes that block's `out_data`/`out_ready` strobe and serialises the byte onto the board TX pin.
- A one-entry holding register lets a second press queue behind a frame already in flight.
- The strobe can stay high for more than one cycle, so a byte is accepted only on the rising edge of `in_valid`.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per UART bit (100 MHz / 9600 baud, truncated); legal range 2..65535.
- CNT_W, 16, width of the bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- in_data  in  8  byte to send; sampled only on an accepting edge
- in_valid  in  1  send request; level may last ≥1 cycle; rising edge only is used
- tx_out  out  1  serial line, idle high, registered
- busy  out  1  high whenever state ≠ IDLE
- hold_full  out  1  holding register occupied
- tx_done  out  1  one-cycle pulse when a stop bit completes
- overflow  out  1  one-cycle pulse when a rising edge is dropped

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (ports clk, rstn).
  - While rstn=0: tx_out=1, busy=0, hold_full=0, tx_done=0, overflow=0, state=IDLE, counters=0, in_valid_d=0.
  - Reset mid-frame aborts the frame immediately: line goes high, no tx_done, holding content discarded.
  - in_valid_d resets to 0, so in_valid held high across reset release counts as a rising edge on the first clock.
- Edge detect: `rise = in_valid & ~in_valid_d`; in_valid_d is registered every cycle.
- States: IDLE, START, DATA, STOP.
  - IDLE, rise: load shifter←in_data, tx_out←0, bit_cnt←0, cyc_cnt←0, go START. tx_out falls on the clock edge after the rise is sampled.
  - START: after CLKS_PER_BIT cycles, tx_out←shifter[0], go DATA.
  - DATA: every CLKS_PER_BIT cycles, shift right and output the next bit, LSB first.
    - After bit 7 has been held CLKS_PER_BIT cycles: tx_out←1, go STOP.
  - STOP: held CLKS_PER_BIT cycles. On the final cycle edge, tx_done←1 (one cycle), then:
    - if hold_full: load shifter←hold, hold_full←0, tx_out←0, go START. No idle gap.
    - else, if rise on that same edge: load in_data directly, go START.
    - else go IDLE.
- Frame length: exactly 10×CLKS_PER_BIT cycles from tx_out falling to the end of the stop bit.
- Rise while state ≠ IDLE:
  - hold_full=0: hold←in_data, hold_full←1.
  - hold_full=1: byte dropped, overflow←1 for one cycle. Exception: on the STOP final edge, hold is vacating, so the new byte takes the holding register and there is no overflow.
- Counters:
  - cyc_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - bit_cnt counts 0..7; no other wrap.
- in_data is ignored on cycles without an accepting rise.
- busy drops in the cycle after the STOP final edge only if nothing is pending.

Decomposition:
- Package uart_pkg:
  - state encoding enum: IDLE=0, START=1, DATA=2, STOP=3
  - DATA_BITS=8, default CLKS_PER_BIT=10416, IDLE_LEVEL=1'b1
- One sub-module, uart_bit_timer:
  - parameterised by CLKS_PER_BIT
  - inputs: clk, rstn, clear, en
  - output: tick, high on the last cycle of each bit period
  - the FSM advances on tick

Test Plan (CLKS_PER_BIT=4):
- Single byte: in_valid=1 for 1 cycle with in_data=0xA5.
  - tx_out reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total).
  - tx_done pulses once at cycle 40; busy is then 0.
- Held strobe: in_valid=1 for 3 cycles with in_data=0x3C.
  - Exactly one frame, decoded 0x3C; overflow stays 0; hold_full stays 0.
- Back-to-back: 0x55, then 0x0F rising during bit 2.
  - hold_full=1 until the first stop ends.
  - The second start bit begins on the cycle after tx_done, with no high gap beyond the 4-cycle stop.
  - Decoded sequence is 0x55, 0x0F.
- Overflow: rises with 0x11, 0x22, 0x33 within the first frame.
  - overflow pulses once (on the 0x33 rise).
  - Line carries 0x11 then 0x22 only.
- Async reset mid-frame: rstn=0 during data bit 3.
  - tx_out=1 without waiting for clk; busy=0, hold_full=0, no tx_done.
  - After release, a new byte 0x81 transmits correctly.
- Reset release with in_valid high and in_data=0x7E.
  - A frame starts on the first clock after release and decodes as 0x7E.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART 8N1 transmitter.
package uart_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   DATA_BITS            = 8;
    localparam int   CLKS_PER_BIT_DEFAULT = 10416;  // 100 MHz / 9600 baud, truncated
    localparam logic IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period. Clear forces the count back to zero.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && !clear && (cnt_q == LAST);

    // Next count: hold while disabled, wrap on the last cycle of the period
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART 8N1 transmitter with a one-entry holding register. Accepts a byte on
// each rising edge of in_valid; a second byte queues behind the frame in flight,
// a third is dropped and flagged on overflow.
//
// state | meaning
// IDLE  | line high, waiting for a rising edge of in_valid
// START | start bit (low) on the line
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); final edge chains to the held byte if any
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       tx_out,
    output logic       busy,
    output logic       hold_full,
    output logic       tx_done,
    output logic       overflow
);

    uart_state_e state_q, state_d;
    logic [7:0]  shifter_q, shifter_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_q, tx_d;
    logic        tx_done_q, tx_done_d;
    logic        overflow_q, overflow_d;
    logic        in_valid_dly_q;
    logic        rise;
    logic        tick;
    logic        final_edge;

    assign rise       = in_valid & ~in_valid_dly_q;
    assign final_edge = (state_q == STOP) && tick;

    // Counter is parked at zero in IDLE so a new frame always starts a full bit
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk   (clk),
        .rstn  (rstn),
        .clear (state_q == IDLE),
        .en    (state_q != IDLE),
        .tick  (tick)
    );

    // Frame sequencing, holding register and status pulses
    always_comb begin
        state_d     = state_q;
        shifter_d   = shifter_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        tx_done_d   = 1'b0;
        overflow_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    shifter_d = in_data;
                    tx_d      = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d      = shifter_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        tx_d    = IDLE_LEVEL;
                        state_d = STOP;
                    end else begin
                        shifter_d = shifter_q >> 1;
                        tx_d      = shifter_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tx_done_d = 1'b1;
                    if (hold_full_q) begin
                        // Held byte goes straight out; a simultaneous new byte takes its place
                        shifter_d   = hold_q;
                        tx_d        = 1'b0;
                        bit_cnt_d   = '0;
                        state_d     = START;
                        hold_full_d = rise;
                        if (rise) begin
                            hold_d = in_data;
                        end
                    end else if (rise) begin
                        shifter_d = in_data;
                        tx_d      = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && !final_edge && rise) begin
            if (!hold_full_q) begin
                hold_d      = in_data;
                hold_full_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // State and datapath registers; reset aborts any frame and idles the line
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            shifter_q      <= '0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            bit_cnt_q      <= '0;
            tx_q           <= IDLE_LEVEL;
            tx_done_q      <= 1'b0;
            overflow_q     <= 1'b0;
            in_valid_dly_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shifter_q      <= shifter_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            bit_cnt_q      <= bit_cnt_d;
            tx_q           <= tx_d;
            tx_done_q      <= tx_done_d;
            overflow_q     <= overflow_d;
            in_valid_dly_q <= in_valid;
        end
    end

    assign tx_out    = tx_q;
    assign busy      = (state_q != IDLE);
    assign hold_full = hold_full_q;
    assign tx_done   = tx_done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame-level reference model plus
// an independent line decoder, directed scenarios and a randomized run.
module tb_uart_tx_buffered;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] in_data;
    logic       in_valid;
    logic       tx_out;
    logic       busy;
    logic       hold_full;
    logic       tx_done;
    logic       overflow;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLKS_PER_BIT (C),
        .CNT_W        (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .tx_out    (tx_out),
        .busy      (busy),
        .hold_full (hold_full),
        .tx_done   (tx_done),
        .overflow  (overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame starts at edge m_start and ends at m_start+10*C
    int         m_n = 0;
    bit         m_busy;
    int         m_start;
    logic [7:0] m_byte;
    bit         m_pend;
    logic [7:0] m_hold;
    bit         m_prev;
    bit         exp_done;
    bit         exp_ovf;
    logic [7:0] m_exp_q[$];

    // Line decoder and scenario bookkeeping
    int         dec_k;
    logic       prev_tx;
    logic [7:0] acc;
    logic [7:0] rx_q[$];
    logic [7:0] dir_q[$];
    int         done_cnt, ovf_cnt, hold_seen;

    function automatic void model_reset();
        m_busy   = 0;
        m_pend   = 0;
        m_prev   = 0;
        exp_done = 0;
        exp_ovf  = 0;
    endfunction

    function automatic void dec_reset();
        dec_k   = -1;
        prev_tx = 1'b1;
    endfunction

    function automatic void model_start(input logic [7:0] b);
        m_busy  = 1;
        m_start = m_n;
        m_byte  = b;
    endfunction

    function automatic void model_edge(input logic v, input logic [7:0] d);
        bit r;
        m_n++;
        if (!rstn) begin
            model_reset();
            return;
        end
        exp_done = 0;
        exp_ovf  = 0;
        r        = v && !m_prev;
        m_prev   = v;
        if (m_busy && m_n == m_start + 10 * C) begin
            exp_done = 1;
            m_exp_q.push_back(m_byte);
            if (m_pend) begin
                model_start(m_hold);
                m_pend = r;
                if (r) m_hold = d;
            end else if (r) begin
                model_start(d);
            end else begin
                m_busy = 0;
            end
        end else if (!m_busy) begin
            if (r) model_start(d);
        end else if (r) begin
            if (!m_pend) begin
                m_pend = 1;
                m_hold = d;
            end else begin
                exp_ovf = 1;
            end
        end
    endfunction

    function automatic logic exp_tx();
        int i;
        if (!m_busy) return 1'b1;
        i = (m_n - m_start) / C;
        if (i == 0) return 1'b0;
        if (i <= 8) return m_byte[i-1];
        return 1'b1;
    endfunction

    task automatic compare_outputs();
        check_val("tx_out", tx_out, exp_tx());
        check_val("busy", busy, m_busy);
        check_val("hold_full", hold_full, m_pend);
        check_val("tx_done", tx_done, exp_done);
        check_val("overflow", overflow, exp_ovf);
        if (tx_done) done_cnt++;
        if (overflow) ovf_cnt++;
        if (hold_full) hold_seen++;
        if (dec_k < 0) begin
            if (prev_tx && !tx_out) dec_k = 0;
        end else begin
            dec_k++;
        end
        if (dec_k > 0) begin
            if (dec_k % C == C / 2 && dec_k / C >= 1 && dec_k / C <= 8)
                acc[dec_k / C - 1] = tx_out;
            if (dec_k == 9 * C + C / 2) begin
                check_val("stop_bit", tx_out, 1);
                rx_q.push_back(acc);
                dec_k = -1;
            end
        end
        prev_tx = tx_out;
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic drain();
        int guard = 0;
        while ((busy || hold_full) && guard < 40 * C) begin
            step(1'b0, 8'($urandom));
            guard++;
        end
        check_val("drain_timeout", {31'd0, busy || hold_full}, 0);
        repeat (2 * C) step(1'b0, 8'($urandom));
    endtask

    task automatic check_rx();
        check_val("rx_count_model", rx_q.size(), m_exp_q.size());
        for (int i = 0; i < rx_q.size() && i < m_exp_q.size(); i++)
            check_val("rx_byte_model", rx_q[i], m_exp_q[i]);
        if (dir_q.size() > 0) begin
            check_val("rx_count_directed", rx_q.size(), dir_q.size());
            for (int i = 0; i < rx_q.size() && i < dir_q.size(); i++)
                check_val("rx_byte_directed", rx_q[i], dir_q[i]);
        end
        rx_q.delete();
        m_exp_q.delete();
        dir_q.delete();
    endtask

    task automatic new_scenario();
        done_cnt  = 0;
        ovf_cnt   = 0;
        hold_seen = 0;
    endtask

    task automatic async_reset_now();
        #2;
        rstn = 1'b0;
        model_reset();
        dec_reset();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v;
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_reset();
        dec_reset();
        new_scenario();
        repeat (3) step(1'b0, 8'h00);
        check_val("reset_tx_out", tx_out, 1);
        check_val("reset_busy", busy, 0);
        rstn = 1'b1;
        repeat (2) step(1'b0, 8'h00);

        // Single byte 0xA5
        new_scenario();
        dir_q = '{8'hA5};
        step(1'b1, 8'hA5);
        repeat (44) step(1'b0, 8'($urandom));
        check_val("single_done_cnt", done_cnt, 1);
        check_val("single_busy_after", busy, 0);
        drain();
        check_rx();

        // Strobe held three cycles
        new_scenario();
        dir_q = '{8'h3C};
        repeat (3) step(1'b1, 8'h3C);
        drain();
        check_val("held_ovf_cnt", ovf_cnt, 0);
        check_val("held_hold_seen", hold_seen, 0);
        check_val("held_done_cnt", done_cnt, 1);
        check_rx();

        // Back-to-back: second byte rises during bit 2
        new_scenario();
        dir_q = '{8'h55, 8'h0F};
        step(1'b1, 8'h55);
        repeat (12) step(1'b0, 8'($urandom));
        step(1'b1, 8'h0F);
        drain();
        check_val("b2b_hold_seen", {31'd0, hold_seen > 0}, 1);
        check_val("b2b_done_cnt", done_cnt, 2);
        check_rx();

        // Overflow: third byte within the first frame is dropped
        new_scenario();
        dir_q = '{8'h11, 8'h22};
        step(1'b1, 8'h11);
        repeat (4) step(1'b0, 8'($urandom));
        step(1'b1, 8'h22);
        repeat (4) step(1'b0, 8'($urandom));
        step(1'b1, 8'h33);
        drain();
        check_val("ovf_cnt", ovf_cnt, 1);
        check_rx();

        // Async reset during data bit 3 with a byte held
        new_scenario();
        step(1'b1, 8'hC3);
        repeat (5) step(1'b0, 8'($urandom));
        step(1'b1, 8'h99);
        repeat (11) step(1'b0, 8'($urandom));
        async_reset_now();
        check_val("arst_tx_out", tx_out, 1);
        check_val("arst_busy", busy, 0);
        check_val("arst_hold_full", hold_full, 0);
        check_val("arst_tx_done", tx_done, 0);
        repeat (2) step(1'b0, 8'h00);
        rstn = 1'b1;
        check_val("arst_done_cnt", done_cnt, 0);
        rx_q.delete();
        m_exp_q.delete();
        dir_q = '{8'h81};
        step(1'b1, 8'h81);
        drain();
        check_rx();

        // Reset release with in_valid already high
        new_scenario();
        async_reset_now();
        repeat (2) step(1'b1, 8'h7E);
        rstn = 1'b1;
        dir_q = '{8'h7E};
        step(1'b1, 8'h7E);
        check_val("release_start", tx_out, 0);
        step(1'b1, 8'h7E);
        drain();
        check_val("release_done_cnt", done_cnt, 1);
        check_rx();

        // Randomized strobes of random length and spacing
        new_scenario();
        v = 1'b0;
        repeat (3000) begin
            v = v ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 24) == 0);
            step(v, 8'($urandom));
        end
        drain();
        check_rx();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
